balls_overlay_render: RTL and testbench

- AXI4-Stream video stage directly downstream of the balls_overlay AXI4-Lite register bank; consumes its ball parameter outputs.
- Paints up to NUM_BALLS filled circles over an RGB pixel stream.
- Sits between the video input path and the display output path.
- Ball parameters are shadowed at start-of-frame, so a frame never tears when software rewrites registers mid-frame.

---
 rtl/balls_overlay_render.sv | 260 ++++++++++++++++++++++++++
 tb/tb_balls_overlay_render.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/balls_overlay_render.sv
// balls_overlay_render: paints filled circles over an AXI4-Stream RGB video
// stream; ball parameters are frozen at start-of-frame for tear-free output.
module balls_overlay_render #(
  parameter int NUM_BALLS = 4,
  parameter int COORD_W   = 11,
  parameter int RAD_W     = 8,
  parameter int PIX_W     = 24
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         overlay_en,
  input  logic [NUM_BALLS-1:0]         ball_en,
  input  logic [NUM_BALLS*COORD_W-1:0] ball_x,
  input  logic [NUM_BALLS*COORD_W-1:0] ball_y,
  input  logic [NUM_BALLS*RAD_W-1:0]   ball_r,
  input  logic [NUM_BALLS*PIX_W-1:0]   ball_color,
  input  logic [PIX_W-1:0]             s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tuser,
  input  logic                         s_axis_tlast,
  output logic [PIX_W-1:0]             m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tuser,
  output logic                         m_axis_tlast,
  output logic                         frame_done
);
  localparam int DW  = COORD_W + 1;
  localparam int SW  = 2 * COORD_W + 1;
  localparam int R2W = 2 * RAD_W;

  typedef struct packed {
    logic             user;
    logic             last;
    logic [PIX_W-1:0] pix;
  } beat_t;

  logic en, acc, xfer;

  logic                         ov_q, ov_d, ov_s;
  logic [NUM_BALLS-1:0]         ben_q, ben_d, ben_s;
  logic [NUM_BALLS*COORD_W-1:0] bx_q, bx_d, bx_s;
  logic [NUM_BALLS*COORD_W-1:0] by_q, by_d, by_s;
  logic [NUM_BALLS*RAD_W-1:0]   br_q, br_d, br_s;
  logic [NUM_BALLS*PIX_W-1:0]   bc_q, bc_d, bc_s;
  logic [COORD_W-1:0]           x_cnt_q, x_cnt_d;
  logic [COORD_W-1:0]           y_cnt_q, y_cnt_d;
  logic [COORD_W-1:0]           cur_x, cur_y;

  logic                 v1_q, v1_d;
  beat_t                b1_q, b1_d;
  logic [NUM_BALLS-1:0] e1_q, e1_d;
  logic signed [DW-1:0] dx_q [NUM_BALLS];
  logic signed [DW-1:0] dx_d [NUM_BALLS];
  logic signed [DW-1:0] dy_q [NUM_BALLS];
  logic signed [DW-1:0] dy_d [NUM_BALLS];
  logic [R2W-1:0]       r2_q [NUM_BALLS];
  logic [R2W-1:0]       r2_d [NUM_BALLS];
  logic [PIX_W-1:0]     c1_q [NUM_BALLS];
  logic [PIX_W-1:0]     c1_d [NUM_BALLS];

  logic                 v2_q, v2_d;
  beat_t                b2_q, b2_d;
  logic [NUM_BALLS-1:0] hit_q, hit_d;
  logic [PIX_W-1:0]     c2_q [NUM_BALLS];
  logic [PIX_W-1:0]     c2_d [NUM_BALLS];

  logic  v3_q, v3_d;
  beat_t b3_q, b3_d;
  beat_t pick;

  logic eol_q, eol_d;
  logic sof_q, sof_d;
  logic fd_q, fd_d;

  function automatic logic in_circle(
    input logic signed [DW-1:0] dx,
    input logic signed [DW-1:0] dy,
    input logic [R2W-1:0]       r2
  );
    logic signed [SW:0] ex, ey, sx, sy;
    logic [SW-1:0]      d2;
    ex = (SW+1)'(dx);
    ey = (SW+1)'(dy);
    sx = ex * ex;
    sy = ey * ey;
    d2 = sx[SW-1:0] + sy[SW-1:0];
    return d2 <= SW'(r2);
  endfunction

  assign en            = !v3_q || m_axis_tready;
  assign s_axis_tready = en;
  assign acc           = s_axis_tvalid && en;
  assign xfer          = v3_q && m_axis_tready;

  assign ov_s  = s_axis_tuser ? overlay_en : ov_q;
  assign ben_s = s_axis_tuser ? ball_en    : ben_q;
  assign bx_s  = s_axis_tuser ? ball_x     : bx_q;
  assign by_s  = s_axis_tuser ? ball_y     : by_q;
  assign br_s  = s_axis_tuser ? ball_r     : br_q;
  assign bc_s  = s_axis_tuser ? ball_color : bc_q;
  assign cur_x = s_axis_tuser ? '0 : x_cnt_q;
  assign cur_y = s_axis_tuser ? '0 : y_cnt_q;

  // coordinate counters and start-of-frame parameter shadows
  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    ov_d    = ov_q;
    ben_d   = ben_q;
    bx_d    = bx_q;
    by_d    = by_q;
    br_d    = br_q;
    bc_d    = bc_q;
    if (acc) begin
      if (s_axis_tlast) begin
        x_cnt_d = '0;
        y_cnt_d = cur_y + COORD_W'(1);
      end else begin
        x_cnt_d = cur_x + COORD_W'(1);
        y_cnt_d = cur_y;
      end
      if (s_axis_tuser) begin
        ov_d  = overlay_en;
        ben_d = ball_en;
        bx_d  = ball_x;
        by_d  = ball_y;
        br_d  = ball_r;
        bc_d  = ball_color;
      end
    end
  end

  // stage 1: centre offsets and squared radius per ball
  always_comb begin
    v1_d = v1_q;
    b1_d = b1_q;
    e1_d = e1_q;
    dx_d = dx_q;
    dy_d = dy_q;
    r2_d = r2_q;
    c1_d = c1_q;
    if (en) begin
      v1_d = acc;
      b1_d = {s_axis_tuser, s_axis_tlast, s_axis_tdata};
      for (int i = 0; i < NUM_BALLS; i++) begin
        e1_d[i] = ov_s && ben_s[i];
        dx_d[i] = $signed({1'b0, cur_x})
                - $signed({1'b0, bx_s[i*COORD_W +: COORD_W]});
        dy_d[i] = $signed({1'b0, cur_y})
                - $signed({1'b0, by_s[i*COORD_W +: COORD_W]});
        r2_d[i] = R2W'(br_s[i*RAD_W +: RAD_W])
                * R2W'(br_s[i*RAD_W +: RAD_W]);
        c1_d[i] = bc_s[i*PIX_W +: PIX_W];
      end
    end
  end

  // stage 2: squared distance and inclusive hit test
  always_comb begin
    v2_d  = v2_q;
    b2_d  = b2_q;
    hit_d = hit_q;
    c2_d  = c2_q;
    if (en) begin
      v2_d = v1_q;
      b2_d = b1_q;
      c2_d = c1_q;
      for (int i = 0; i < NUM_BALLS; i++) begin
        hit_d[i] = e1_q[i] && in_circle(dx_q[i], dy_q[i], r2_q[i]);
      end
    end
  end

  // stage 3: lowest-index hit ball wins, else pass the pixel through
  always_comb begin
    pick = b2_q;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (hit_q[i]) pick.pix = c2_q[i];
    end
    v3_d = v3_q;
    b3_d = b3_q;
    if (en) begin
      v3_d = v2_q;
      b3_d = pick;
    end
  end

  // frame completion: an output SOF right after an output EOL
  always_comb begin
    eol_d = xfer ? b3_q.last : eol_q;
    sof_d = sof_q || (xfer && b3_q.user);
    fd_d  = xfer && b3_q.user && eol_q && sof_q;
  end

  // state registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      ov_q    <= 1'b0;
      ben_q   <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      br_q    <= '0;
      bc_q    <= '0;
      v1_q    <= 1'b0;
      b1_q    <= '0;
      e1_q    <= '0;
      v2_q    <= 1'b0;
      b2_q    <= '0;
      hit_q   <= '0;
      v3_q    <= 1'b0;
      b3_q    <= '0;
      eol_q   <= 1'b0;
      sof_q   <= 1'b0;
      fd_q    <= 1'b0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        dx_q[i] <= '0;
        dy_q[i] <= '0;
        r2_q[i] <= '0;
        c1_q[i] <= '0;
        c2_q[i] <= '0;
      end
    end else begin
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      ov_q    <= ov_d;
      ben_q   <= ben_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      br_q    <= br_d;
      bc_q    <= bc_d;
      v1_q    <= v1_d;
      b1_q    <= b1_d;
      e1_q    <= e1_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      r2_q    <= r2_d;
      c1_q    <= c1_d;
      v2_q    <= v2_d;
      b2_q    <= b2_d;
      hit_q   <= hit_d;
      c2_q    <= c2_d;
      v3_q    <= v3_d;
      b3_q    <= b3_d;
      eol_q   <= eol_d;
      sof_q   <= sof_d;
      fd_q    <= fd_d;
    end
  end

  assign m_axis_tvalid = v3_q;
  assign m_axis_tdata  = b3_q.pix;
  assign m_axis_tuser  = b3_q.user;
  assign m_axis_tlast  = b3_q.last;
  assign frame_done    = fd_q;

endmodule

// File: tb/tb_balls_overlay_render.sv
// tb_balls_overlay_render: random and directed frames checked against a
// per-pixel circle model, with random output backpressure.
module tb_balls_overlay_render;
  localparam int NB = 4;
  localparam int CW = 11;
  localparam int RW = 8;
  localparam int PW = 24;
  localparam logic [PW-1:0] BG  = 24'h101010;
  localparam logic [PW-1:0] RED = 24'hFF0000;
  localparam logic [PW-1:0] GRN = 24'h00FF00;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic              overlay_en;
  logic [NB-1:0]     ball_en;
  logic [NB*CW-1:0]  ball_x;
  logic [NB*CW-1:0]  ball_y;
  logic [NB*RW-1:0]  ball_r;
  logic [NB*PW-1:0]  ball_color;
  logic [PW-1:0]     s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic              s_axis_tuser = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic [PW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tuser;
  logic              m_axis_tlast;
  logic              frame_done;

  balls_overlay_render dut (
    .aclk          (aclk),
    .areset        (areset),
    .overlay_en    (overlay_en),
    .ball_en       (ball_en),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .ball_r        (ball_r),
    .ball_color    (ball_color),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .frame_done    (frame_done)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // software-visible ball registers
  logic          ov = 1'b0;
  logic [NB-1:0] ben = '0;
  int            bx [NB];
  int            by [NB];
  int            br [NB];
  logic [PW-1:0] bcol [NB];

  // model's frame-latched copy
  logic          sh_ov = 1'b0;
  logic [NB-1:0] sh_en = '0;
  int            sh_bx [NB];
  int            sh_by [NB];
  int            sh_r  [NB];
  logic [PW-1:0] sh_c  [NB];

  always_comb begin
    overlay_en = ov;
    ball_en    = ben;
    ball_x     = '0;
    ball_y     = '0;
    ball_r     = '0;
    ball_color = '0;
    for (int i = 0; i < NB; i++) begin
      ball_x[i*CW +: CW]     = CW'(bx[i]);
      ball_y[i*CW +: CW]     = CW'(by[i]);
      ball_r[i*RW +: RW]     = RW'(br[i]);
      ball_color[i*PW +: PW] = bcol[i];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_pix(input int x, input int y,
                                            input logic [PW-1:0] p);
    for (int i = 0; i < NB; i++) begin
      if (sh_ov && sh_en[i]) begin
        int dx, dy;
        dx = x - sh_bx[i];
        dy = y - sh_by[i];
        if (dx * dx + dy * dy <= sh_r[i] * sh_r[i]) return sh_c[i];
      end
    end
    return p;
  endfunction

  logic [PW+1:0] exp_q [$];
  logic [PW-1:0] img [16][16];
  int  gap_pct = 0;
  bit  rnd_rdy = 1'b0;
  bit  rec_acc = 1'b0;
  int  acc_cyc = 0;
  int  first_cyc = 0;
  bit  first_seen = 1'b0;
  int  out_cnt = 0;
  int  fd_cnt = 0;
  int  exp_fd = 0;
  bit  fr_ok = 1'b0;

  // output sink: random ready, ordered compare, hold-stability check
  always begin : mon
    int ox, oy;
    bit held;
    logic [PW+2:0] hv;
    logic [PW+1:0] e;
    @(negedge aclk);
    m_axis_tready = rnd_rdy ? ($urandom_range(1) == 1) : 1'b1;
    #1;
    if (areset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_hold",
            {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, hv);
      end
      held = m_axis_tvalid && !m_axis_tready;
      hv = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, e);
        end
        if (!first_seen) begin
          first_seen = 1'b1;
          first_cyc = cyc;
        end
        out_cnt++;
        if (m_axis_tuser) begin
          ox = 0;
          oy = 0;
        end
        if (ox < 16 && oy < 16) img[oy][ox] = m_axis_tdata;
        if (m_axis_tlast) begin
          ox = 0;
          oy++;
        end else begin
          ox++;
        end
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic send_beat(input logic [PW-1:0] d, input logic u,
                           input logic l, input int x, input int y);
    int n;
    if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    #1;
    n = 0;
    while (!s_axis_tready && n < 500) begin
      @(negedge aclk);
      #1;
      n++;
    end
    if (!s_axis_tready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    if (rec_acc) begin
      acc_cyc = cyc;
      rec_acc = 1'b0;
    end
    if (u) begin
      sh_ov = ov;
      sh_en = ben;
      for (int i = 0; i < NB; i++) begin
        sh_bx[i] = bx[i];
        sh_by[i] = by[i];
        sh_r[i]  = br[i];
        sh_c[i]  = bcol[i];
      end
    end
    exp_q.push_back({u, l, ref_pix(x, y, d)});
  endtask

  task automatic send_frame(input int w, input int h, input bit rnd,
                            input bit chg, input int stop);
    int k = 0;
    if (fr_ok) exp_fd++;
    fr_ok = 1'b0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (chg && y == 2 && x == 0) bx[0] = 6;
        if (stop >= 0 && k == stop) return;
        send_beat(rnd ? PW'($urandom) : BG, x == 0 && y == 0,
                  x == w - 1, x, y);
        k++;
      end
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    fr_ok = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge aclk);
      #2;
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(negedge aclk);
  endtask

  task automatic set_ball(input int i, input int x, input int y,
                          input int r, input logic [PW-1:0] c);
    bx[i]   = x;
    by[i]   = y;
    br[i]   = r;
    bcol[i] = c;
  endtask

  initial begin
    for (int i = 0; i < NB; i++) set_ball(i, 0, 0, 0, '0);
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tuser_tlast", {m_axis_tuser, m_axis_tlast}, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_tready", s_axis_tready, 1);

    // single ball, full-rate
    set_ball(0, 3, 3, 2, RED);
    ben = 4'b0001;
    ov = 1'b1;
    rec_acc = 1'b1;
    send_frame(8, 8, 0, 0, -1);
    drain();
    chk("latency", first_cyc - acc_cyc, 3);
    chk("p31", img[1][3], RED);
    chk("p13", img[3][1], RED);
    chk("p53", img[3][5], RED);
    chk("p35", img[5][3], RED);
    chk("p44", img[4][4], RED);
    chk("p54", img[4][5], BG);
    chk("p00", img[0][0], BG);

    // overlap priority
    set_ball(1, 4, 3, 2, GRN);
    ben = 4'b0011;
    send_frame(8, 8, 0, 0, -1);
    drain();
    chk("prio_43", img[3][4], RED);
    chk("prio_63", img[3][6], GRN);
    ben = 4'b0010;
    send_frame(8, 8, 0, 0, -1);
    drain();
    chk("only1_43", img[3][4], GRN);

    // backpressure, continuous input
    ben = 4'b0011;
    rnd_rdy = 1'b1;
    out_cnt = 0;
    send_frame(16, 4, 1, 0, -1);
    drain();
    chk("beats_16x4", out_cnt, 64);

    // mid-frame register rewrite, then overlay disable
    rnd_rdy = 1'b0;
    ben = 4'b0001;
    set_ball(0, 3, 3, 2, RED);
    send_frame(8, 8, 0, 1, -1);
    drain();
    chk("tear_33", img[3][3], RED);
    chk("tear_63", img[3][6], BG);
    send_frame(8, 8, 0, 0, -1);
    drain();
    chk("moved_63", img[3][6], RED);
    chk("moved_33", img[3][3], BG);
    ov = 1'b0;
    send_frame(8, 8, 0, 0, -1);
    drain();
    chk("off_63", img[3][6], BG);

    // corner ball, r=1 then r=0
    ov = 1'b1;
    set_ball(0, 0, 0, 1, RED);
    send_frame(8, 8, 0, 0, -1);
    drain();
    chk("c1_00", img[0][0], RED);
    chk("c1_10", img[0][1], RED);
    chk("c1_01", img[1][0], RED);
    chk("c1_11", img[1][1], BG);
    br[0] = 0;
    send_frame(8, 8, 0, 0, -1);
    drain();
    chk("c0_00", img[0][0], RED);
    chk("c0_10", img[0][1], BG);
    chk("c0_01", img[1][0], BG);

    // random balls, sizes, gaps and backpressure
    rnd_rdy = 1'b1;
    gap_pct = 30;
    for (int f = 0; f < 8; f++) begin
      ov  = ($urandom_range(3) != 0);
      ben = NB'($urandom);
      for (int i = 0; i < NB; i++) begin
        bx[i] = ($urandom_range(3) == 0) ? int'($urandom_range(2047))
                                         : int'($urandom_range(15));
        by[i] = ($urandom_range(3) == 0) ? int'($urandom_range(2047))
                                         : int'($urandom_range(8));
        br[i] = ($urandom_range(7) == 0) ? int'($urandom_range(255))
                                         : int'($urandom_range(5));
        bcol[i] = PW'($urandom);
      end
      send_frame(int'($urandom_range(1, 12)), int'($urandom_range(1, 6)),
                 1, 0, -1);
    end
    drain();

    // reset mid-frame with beats in flight
    rnd_rdy = 1'b0;
    gap_pct = 0;
    ov = 1'b1;
    ben = 4'b0001;
    set_ball(0, 3, 3, 2, RED);
    send_frame(8, 8, 0, 0, 20);
    @(negedge aclk);
    #1;
    chk("pending_before_rst", m_axis_tvalid, 1);
    s_axis_tvalid = 1'b0;
    areset = 1'b1;
    exp_q.delete();
    fr_ok = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("tvalid_after_rst", m_axis_tvalid, 0);
    send_frame(8, 8, 0, 0, -1);
    drain();
    chk("post_rst_33", img[3][3], RED);
    chk("post_rst_00", img[0][0], BG);
    send_frame(8, 8, 0, 0, -1);
    drain();
    repeat (5) @(negedge aclk);
    chk("frame_done_count", fd_cnt, exp_fd);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
